// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready input and a multi-cycle shift-add multiplier
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   in_valid       in   a, b and instruction_en are valid this cycle
//   in_ready       out  block accepts an op this cycle (IDLE and not in reset)
//   a              in   accumulator operand
//   b              in   bus operand / immediate source (low IMM_WIDTH bits)
//   instruction_en in   one-hot op select, bit positions from alu_seq_pkg
//   out_valid      out  one-cycle pulse when c/flags hold a new result
//   c              out  result, held between pulses
//   flags          out  EQ, GT, Z, C, ILL at the alu_seq_pkg indices
package alu_seq_pkg;
    localparam int ISA_ADD = 0;
    localparam int ISA_ADDI = 1;
    localparam int ISA_SH = 2;
    localparam int ISA_SHI = 3;
    localparam int ISA_NOT = 4;
    localparam int ISA_AND = 5;
    localparam int ISA_OR = 6;
    localparam int ISA_XOR = 7;
    localparam int ISA_MUL = 8;
    localparam int ISA_INSTRUCTION_COUNT = 9;
    localparam int ALU_FLAG_EQ = 0;
    localparam int ALU_FLAG_GT = 1;
    localparam int ALU_FLAG_Z = 2;
    localparam int ALU_FLAG_C = 3;
    localparam int ALU_FLAG_ILL = 4;
endpackage

module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IMM_WIDTH = 4,
    parameter int FLAG_COUNT = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 a,
    input  logic [WIDTH-1:0]                 b,
    input  logic [ISA_INSTRUCTION_COUNT-1:0] instruction_en,
    output logic                             out_valid,
    output logic [WIDTH-1:0]                 c,
    output logic [FLAG_COUNT-1:0]            flags
);
    localparam int N = ISA_INSTRUCTION_COUNT;
    localparam int CW = $clog2(WIDTH);
    localparam logic [N-1:0] MUL_HOT = {{(N-1){1'b0}}, 1'b1} << ISA_MUL;

    typedef enum logic {IDLE, MUL_RUN} state_t;
    state_t state, state_next;

    logic [WIDTH-1:0] op_a, op_b, imm, mplier, res;
    logic [N-1:0] op_sel;
    logic [2*WIDTH-1:0] mcand, prod;
    logic [WIDTH:0] sum;
    logic [CW-1:0] cnt;
    logic [FLAG_COUNT-1:0] alu_flags, mul_flags;
    logic accept, is_mul, last, pend, mul_done, ill, cy;

    function automatic logic [FLAG_COUNT-1:0] pack_flags(input logic eq, gt, z, cf, il);
        logic [FLAG_COUNT-1:0] f;
        f = '0;
        f[ALU_FLAG_EQ] = eq;
        f[ALU_FLAG_GT] = gt;
        f[ALU_FLAG_Z] = z;
        f[ALU_FLAG_C] = cf;
        f[ALU_FLAG_ILL] = il;
        return f;
    endfunction

    assign in_ready = (state == IDLE) && !rst;
    assign accept = in_valid && in_ready;
    assign is_mul = instruction_en == MUL_HOT;
    assign last = cnt == CW'(WIDTH - 1);
    assign imm = {{(WIDTH-IMM_WIDTH){1'b0}}, op_b[IMM_WIDTH-1:0]};

    always_comb begin
        state_next = (state == IDLE) ? ((accept && is_mul) ? MUL_RUN : IDLE)
                                     : (last ? IDLE : MUL_RUN);
    end

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_next;
    end

    // Single-cycle ops evaluate the operands latched at accept, one edge later.
    always_comb begin
        sum = {1'b0, op_a} + {1'b0, op_sel[ISA_ADDI] ? imm : op_b};
        ill = !$onehot(op_sel) || op_sel[ISA_MUL];
        res = ill                 ? '0 :
              op_sel[ISA_ADD]     ? sum[WIDTH-1:0] :
              op_sel[ISA_ADDI]    ? sum[WIDTH-1:0] :
              op_sel[ISA_SH]      ? op_a << op_b :
              op_sel[ISA_SHI]     ? op_a << imm :
              op_sel[ISA_NOT]     ? ~op_a :
              op_sel[ISA_AND]     ? op_a & op_b :
              op_sel[ISA_OR]      ? op_a | op_b : op_a ^ op_b;
        cy = !ill && (op_sel[ISA_ADD] || op_sel[ISA_ADDI]) && sum[WIDTH];
        alu_flags = pack_flags(op_a == op_b, op_b > op_a, res == '0, cy, ill);
        mul_flags = pack_flags(op_a == op_b, op_b > op_a, prod[WIDTH-1:0] == '0,
                               |prod[2*WIDTH-1:WIDTH], 1'b0);
    end

    // The MUL result is published one edge after the final partial product,
    // which places out_valid WIDTH+1 edges after accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
            mul_done <= 1'b0;
            out_valid <= 1'b0;
            cnt <= '0;
            c <= '0;
            flags <= '0;
            prod <= '0;
            mcand <= '0;
            mplier <= '0;
            op_a <= '0;
            op_b <= '0;
            op_sel <= '0;
        end else begin
            pend <= accept && !is_mul;
            mul_done <= (state == MUL_RUN) && last;
            out_valid <= pend || mul_done;
            if (accept) begin
                op_a <= a;
                op_b <= b;
                op_sel <= instruction_en;
            end
            if (accept && is_mul) begin
                mcand <= {{WIDTH{1'b0}}, a};
                mplier <= b;
                prod <= '0;
                cnt <= '0;
            end else if (state == MUL_RUN) begin
                prod <= prod + (mplier[0] ? mcand : '0);
                mcand <= mcand << 1;
                mplier <= mplier >> 1;
                cnt <= last ? '0 : cnt + 1'b1;
            end
            if (pend) begin
                c <= res;
                flags <= alu_flags;
            end else if (mul_done) begin
                c <= prod[WIDTH-1:0];
                flags <= mul_flags;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq against an arithmetic reference model
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic [8:0] instruction_en = '0;
    logic in_ready, out_valid;
    logic [7:0] c;
    logic [4:0] flags;
    int errors = 0, checks = 0;

    alu_seq #(.WIDTH(8), .IMM_WIDTH(4), .FLAG_COUNT(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .instruction_en(instruction_en),
        .out_valid(out_valid), .c(c), .flags(flags)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [8:0] hot(input int i);
        logic [8:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Returns {flags, c} from plain integer arithmetic on the op definitions.
    function automatic logic [12:0] model(input logic [8:0] op, input logic [7:0] x, y);
        int r, amt;
        logic cf, il;
        logic [7:0] cv;
        logic [4:0] f;
        r = 0;
        cf = 1'b0;
        il = $countones(op) != 1;
        amt = int'(y) % 16;
        if (!il) begin
            if (op[ISA_ADD]) begin r = int'(x) + int'(y); cf = r > 255; end
            else if (op[ISA_ADDI]) begin r = int'(x) + amt; cf = r > 255; end
            else if (op[ISA_SH]) r = (y >= 8) ? 0 : int'(x) << y;
            else if (op[ISA_SHI]) r = (amt >= 8) ? 0 : int'(x) << amt;
            else if (op[ISA_NOT]) r = 255 - int'(x);
            else if (op[ISA_AND]) r = int'(x & y);
            else if (op[ISA_OR]) r = int'(x | y);
            else if (op[ISA_XOR]) r = int'(x ^ y);
            else begin r = int'(x) * int'(y); cf = r > 255; end
        end
        cv = 8'(r % 256);
        f = '0;
        f[ALU_FLAG_EQ] = x == y;
        f[ALU_FLAG_GT] = y > x;
        f[ALU_FLAG_Z] = cv == 0;
        f[ALU_FLAG_C] = cf;
        f[ALU_FLAG_ILL] = il;
        return {f, cv};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [8:0] op, input logic [7:0] x, y, output bit ok);
        instruction_en = op;
        a = x;
        b = y;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = in_ready;
            step;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 30) begin
            step;
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b1;
        instruction_en = hot(ISA_ADD);
        a = 8'h01;
        b = 8'h02;
        step;
        step;
        checks++; if (c !== 8'h00) begin errors++; $display("FAIL reset_c: got %h want 00", c); end
        checks++; if (flags !== 5'h00) begin errors++; $display("FAIL reset_flags: got %b want 00000", flags); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
        step;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_accept: got %b want 0", out_valid); end
    endtask

    task automatic test_add;
        bit ok;
        int n;
        logic [12:0] e;
        e = model(hot(ISA_ADD), 8'hF0, 8'h20);
        issue(hot(ISA_ADD), 8'hF0, 8'h20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL add_accept: got 0 want 1"); end
        wait_out(n);
        checks++; if (n !== 1) begin errors++; $display("FAIL add_latency: got %0d want 1", n); end
        checks++; if (c !== 8'h10) begin errors++; $display("FAIL add_c: got %h want 10", c); end
        checks++; if (flags !== e[12:8]) begin errors++; $display("FAIL add_flags: got %b want %b", flags, e[12:8]); end
        step;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_pulse: got %b want 0", out_valid); end
        checks++; if (c !== 8'h10) begin errors++; $display("FAIL add_hold: got %h want 10", c); end
        e = model(hot(ISA_ADDI), 8'h05, 8'hFA);
        issue(hot(ISA_ADDI), 8'h05, 8'hFA, ok);
        wait_out(n);
        checks++; if (n !== 1) begin errors++; $display("FAIL addi_latency: got %0d want 1", n); end
        checks++; if (c !== 8'h0F) begin errors++; $display("FAIL addi_c: got %h want 0f", c); end
        checks++; if (flags !== e[12:8]) begin errors++; $display("FAIL addi_flags: got %b want %b", flags, e[12:8]); end
    endtask

    task automatic test_back_to_back;
        logic [12:0] exp_q[20];
        logic [8:0] op;
        logic [7:0] x, y;
        instruction_en = hot(ISA_XOR); a = 8'h5A; b = 8'h5A; in_valid = 1'b1;
        step;
        instruction_en = hot(ISA_SHI); a = 8'h03; b = 8'h02;
        step;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_first_valid: got %b want 1", out_valid); end
        checks++; if ({flags, c} !== {5'b00101, 8'h00}) begin errors++; $display("FAIL b2b_xor: got %b/%h want 00101/00", flags, c); end
        step;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_valid: got %b want 1", out_valid); end
        checks++; if ({flags, c} !== {5'b00000, 8'h0C}) begin errors++; $display("FAIL b2b_shi: got %b/%h want 00000/0c", flags, c); end
        step;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b want 0", out_valid); end
        for (int t = 0; t <= 20; t++) begin
            if (t < 20) begin
                op = ($urandom_range(0, 9) == 0) ? 9'(3 << $urandom_range(0, 6)) : hot($urandom_range(0, 7));
                x = 8'($urandom);
                y = 8'($urandom);
                exp_q[t] = model(op, x, y);
                instruction_en = op; a = x; b = y; in_valid = 1'b1;
            end else in_valid = 1'b0;
            step;
            if (t >= 1) begin
                checks++;
                if (out_valid !== 1'b1 || {flags, c} !== exp_q[t-1]) begin
                    errors++;
                    $display("FAIL stream_%0d: got v=%b %b/%h want v=1 %b/%h", t - 1, out_valid, flags, c, exp_q[t-1][12:8], exp_q[t-1][7:0]);
                end
            end
        end
        step;
    endtask

    task automatic test_shift;
        bit ok;
        int n;
        issue(hot(ISA_SH), 8'h03, 8'h0A, ok);
        wait_out(n);
        checks++; if (c !== 8'h00) begin errors++; $display("FAIL sh_big_c: got %h want 00", c); end
        checks++; if (flags !== 5'b00110) begin errors++; $display("FAIL sh_big_flags: got %b want 00110", flags); end
    endtask

    task automatic test_mul;
        bit ok;
        int n;
        logic [12:0] e;
        e = model(hot(ISA_MUL), 8'h0C, 8'h0B);
        issue(hot(ISA_MUL), 8'h0C, 8'h0B, ok);
        for (int i = 0; i < 8; i++) begin
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL mul_busy_%0d: got rdy=%b v=%b want 0 0", i, in_ready, out_valid); end
            if (i == 3) begin instruction_en = hot(ISA_ADD); a = 8'h01; b = 8'h01; in_valid = 1'b1; end
            if (i == 4) in_valid = 1'b0;
            step;
        end
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mul_idle8: got rdy=%b v=%b want 1 0", in_ready, out_valid); end
        step;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mul_valid9: got %b want 1", out_valid); end
        checks++; if (c !== 8'h84) begin errors++; $display("FAIL mul_c: got %h want 84", c); end
        checks++; if (flags !== e[12:8]) begin errors++; $display("FAIL mul_flags: got %b want %b", flags, e[12:8]); end
        step;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mul_ignored_in: got %b want 0", out_valid); end
        issue(hot(ISA_MUL), 8'h10, 8'h10, ok);
        wait_out(n);
        checks++; if (n !== 9) begin errors++; $display("FAIL mul2_latency: got %0d want 9", n); end
        checks++; if ({flags, c} !== {5'b01101, 8'h00}) begin errors++; $display("FAIL mul2: got %b/%h want 01101/00", flags, c); end
    endtask

    task automatic test_abort;
        bit ok;
        int seen;
        issue(hot(ISA_MUL), 8'h07, 8'h09, ok);
        step; step; step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", in_ready); end
        checks++; if (flags !== 5'b00000) begin errors++; $display("FAIL abort_flags: got %b want 00000", flags); end
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid === 1'b1) seen++;
            step;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_valid: got %0d pulses want 0", seen); end
    endtask

    task automatic test_illegal;
        bit ok;
        int n;
        issue(hot(ISA_ADD) | hot(ISA_AND), 8'h33, 8'h33, ok);
        wait_out(n);
        checks++; if (n !== 1) begin errors++; $display("FAIL ill_latency: got %0d want 1", n); end
        checks++; if ({flags, c} !== {5'b10101, 8'h00}) begin errors++; $display("FAIL ill_multi: got %b/%h want 10101/00", flags, c); end
        issue(9'h000, 8'h01, 8'h02, ok);
        wait_out(n);
        checks++; if ({flags, c} !== {5'b10110, 8'h00}) begin errors++; $display("FAIL ill_zero: got %b/%h want 10110/00", flags, c); end
    endtask

    task automatic test_random;
        bit ok;
        int n;
        logic [8:0] op;
        logic [7:0] x, y;
        logic [12:0] e;
        for (int i = 0; i < 60; i++) begin
            op = hot($urandom_range(0, 8));
            if ($urandom_range(0, 9) == 0) op = 9'($urandom);
            if ($countones(op) == 1 && op != hot(ISA_MUL) && $urandom_range(0, 3) == 0) op = hot(ISA_MUL);
            x = 8'($urandom);
            y = ($urandom_range(0, 7) == 0) ? x : 8'($urandom);
            e = model(op, x, y);
            issue(op, x, y, ok);
            wait_out(n);
            checks++;
            if (n !== (op == hot(ISA_MUL) ? 9 : 1) || {flags, c} !== e) begin
                errors++;
                $display("FAIL rand_%0d op=%b a=%h b=%h: got lat=%0d %b/%h want %b/%h", i, op, x, y, n, flags, c, e[12:8], e[7:0]);
            end
            step;
            checks++; if (out_valid !== 1'b0 || c !== e[7:0]) begin errors++; $display("FAIL rand_hold_%0d: got v=%b c=%h want v=0 c=%h", i, out_valid, c, e[7:0]); end
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_back_to_back;
        test_shift;
        test_mul;
        test_abort;
        test_illegal;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
